if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the fetch PC and drives a req/addr_ok/data_ok instruction-memory bus with one outstanding request.
- Feeds decode through an IF/ID register: o_pc, o_inst, o_valid.
- Takes the next-PC select (pcsource, bpc, jpc, jrpc) and the stall produced by decode, and honours the MIPS branch delay slot.

Parameters:
- RESET_PC, 32'hBFC00000, address of the first fetch after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  decode cannot accept; IF/ID contents held.
- pcsource  in  2  00 sequential, 01 bpc, 10 jrpc, 11 jpc; valid while o_valid.
- bpc  in  32  branch target.
- jrpc  in  32  jump-register target.
- jpc  in  32  jump target.
- inst_req  out  1  fetch request.
- inst_addr  out  32  fetch address; stable while inst_req && !inst_addr_ok.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  read data returned this cycle.
- inst_rdata  in  32  instruction word.
- o_pc  out  32  PC of the instruction in IF/ID.
- o_inst  out  32  instruction in IF/ID.
- o_valid  out  1  IF/ID holds a valid instruction.
- o_adel  out  1  fetch address error, with the instruction in IF/ID.

Behaviour:
- Reset values: fetch_pc=RESET_PC, inst_req=0, inst_addr=RESET_PC, o_pc=0, o_inst=0, o_valid=0, o_adel=0. All internal state cleared: FSM=REQ, redirect_valid=0, buffer empty. Reset mid-transaction drops the outstanding request; a data_ok arriving after reset deasserts is ignored.
- "Accept" means o_valid && !stall.
- FSM, three states:
  - REQ: inst_req=1, inst_addr=fetch_pc. On inst_addr_ok go to WAIT and record req_pc=fetch_pc. fetch_pc advances per the redirect rule below.
  - WAIT: inst_req=0. On inst_data_ok:
    - if IF/ID is empty or being accepted this cycle, load o_inst=inst_rdata, o_pc=req_pc, o_valid=1, and go to REQ;
    - otherwise store the word in a one-entry buffer and go to HOLD.
  - HOLD: inst_req=0. When IF/ID is accepted, move the buffer into IF/ID and go to REQ.
- IF/ID: on accept with no new word available, o_valid drops to 0. Under stall, o_pc/o_inst/o_valid hold.
- Latency: data_ok in cycle N gives o_valid in cycle N+1. With a zero-wait bus (addr_ok same cycle, data_ok next cycle), throughput is one instruction per 2 cycles.
- Redirect (delay slot):
  - On accept with pcsource!=00, latch redirect_pc (bpc, jrpc or jpc per select), set redirect_valid=1, and record ds_pc=o_pc+4.
  - When a request is accepted in REQ:
    - if redirect_valid and fetch_pc!=ds_pc, the request just sent was the one after the delay slot. It is squashed: its returned data is discarded and never enters IF/ID. Then fetch_pc=redirect_pc and redirect_valid=0.
    - if fetch_pc==ds_pc, the delay slot is fetched normally, redirect stays pending, and fetch_pc=fetch_pc+4.
    - otherwise fetch_pc=fetch_pc+4.
  - A second redirect while one is pending cannot occur (a branch in a delay slot is undefined). The implementation keeps the newest.
- Wrap-around: fetch_pc+4 wraps modulo 2^32 without flagging.
- Arithmetic: all PC arithmetic is 32-bit unsigned.

Optional Feature:
- Macro: IF_ADEL_EN.
- Defined:
  - In REQ, if fetch_pc[1:0]!=0, no bus request is issued (inst_req=0).
  - Instead, when IF/ID can load, the stage writes o_pc=fetch_pc, o_inst=0, o_valid=1, o_adel=1 and stops fetching.
  - It stays stopped until a redirect is latched, which resumes at redirect_pc with o_adel cleared on the next load, or until reset.
- Undefined: o_adel is tied 0 and the low two address bits are passed to the bus unchecked.

Test Plan:
- Reset release, zero-wait bus, stall=0 -> first inst_addr=0xBFC00000; o_pc sequence BFC00000, BFC00004, BFC00008; o_valid in cycle after each data_ok.
- stall=1 for 3 cycles while word for BFC00008 returns -> FSM enters HOLD, o_pc stays BFC00004 for 3 cycles, then BFC00008 with no word lost or duplicated.
- Branch at 0xBFC00010, pcsource=01, bpc=0xBFC00100 -> o_pc sequence BFC00010, BFC00014 (delay slot), BFC00100; BFC00018 never reaches o_valid.
- Same branch with delay-slot request not yet issued (addr_ok held 0 for 4 cycles) -> BFC00014 still fetched, then BFC00100.
- Reset asserted in WAIT, with data_ok arriving during reset -> outputs at reset values; the first request after release is BFC00000.
- IF_ADEL_EN, jrpc=0x00400002 via pcsource=10 -> o_valid=1, o_adel=1, o_pc=0x00400002, no inst_req until the next redirect.

Source files
------------

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the fetch PC, drives a one-outstanding req/addr_ok/data_ok bus, feeds IF/ID.
// Build option IF_ADEL_EN: misaligned fetch addresses become an address-error entry instead of a bus request.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jrpc,
  input  logic [31:0] jpc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid,
  output logic        o_adel
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        squash_q, squash_d;
  logic [31:0] buf_q, buf_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] ds_pc_q, ds_pc_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        accept, can_load, handshake;
  logic [31:0] redir_tgt;
`ifdef IF_ADEL_EN
  logic        adel_q, adel_d;
  logic        stopped_q, stopped_d;
`endif

  assign accept    = valid_q && !stall;
  assign can_load  = !valid_q || accept;
  assign handshake = req_q && inst_addr_ok;

  always_comb begin
    case (pcsource)
      2'b01:   redir_tgt = bpc;
      2'b10:   redir_tgt = jrpc;
      default: redir_tgt = jpc;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    squash_d      = squash_q;
    buf_d         = buf_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    ds_pc_d       = ds_pc_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    valid_d       = valid_q;
`ifdef IF_ADEL_EN
    adel_d        = adel_q;
    stopped_d     = stopped_q;
`endif
    if (accept) valid_d = 1'b0;

    case (state_q)
      S_REQ: begin
`ifdef IF_ADEL_EN
        if (stopped_q) begin
          if (redir_valid_q) begin
            fetch_pc_d    = redir_pc_q;
            redir_valid_d = 1'b0;
            stopped_d     = 1'b0;
          end
        end else if (fetch_pc_q[1:0] != 2'b00) begin
          if (can_load) begin
            pc_d      = fetch_pc_q;
            inst_d    = '0;
            valid_d   = 1'b1;
            adel_d    = 1'b1;
            stopped_d = 1'b1;
          end
        end else
`endif
        if (handshake) begin
          state_d  = S_WAIT;
          req_pc_d = fetch_pc_q;
          // A pending redirect with fetch_pc past the delay slot means this request must die.
          if (redir_valid_q && (fetch_pc_q != ds_pc_q)) begin
            squash_d      = 1'b1;
            fetch_pc_d    = redir_pc_q;
            redir_valid_d = 1'b0;
          end else begin
            squash_d   = 1'b0;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d = S_REQ;
          if (squash_q) begin
            squash_d = 1'b0;
          end else if (can_load) begin
            pc_d    = req_pc_q;
            inst_d  = inst_rdata;
            valid_d = 1'b1;
`ifdef IF_ADEL_EN
            adel_d  = 1'b0;
`endif
          end else begin
            buf_d   = inst_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (accept) begin
          pc_d    = req_pc_q;
          inst_d  = buf_q;
          valid_d = 1'b1;
          state_d = S_REQ;
`ifdef IF_ADEL_EN
          adel_d  = 1'b0;
`endif
        end
      end
      default: state_d = S_REQ;
    endcase

    // Latched after the FSM so a newer redirect overrides anything the FSM consumed.
    if (accept && (pcsource != 2'b00)) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = redir_tgt;
      ds_pc_d       = pc_q + 32'd4;
    end

`ifdef IF_ADEL_EN
    req_d = (state_d == S_REQ) && !stopped_d && (fetch_pc_d[1:0] == 2'b00);
`else
    req_d = (state_d == S_REQ);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      squash_q      <= 1'b0;
      buf_q         <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      ds_pc_q       <= '0;
      req_q         <= 1'b0;
      pc_q          <= '0;
      inst_q        <= '0;
      valid_q       <= 1'b0;
`ifdef IF_ADEL_EN
      adel_q        <= 1'b0;
      stopped_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      squash_q      <= squash_d;
      buf_q         <= buf_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      ds_pc_q       <= ds_pc_d;
      req_q         <= req_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      valid_q       <= valid_d;
`ifdef IF_ADEL_EN
      adel_q        <= adel_d;
      stopped_q     <= stopped_d;
`endif
    end
  end

  assign inst_req  = req_q;
  assign inst_addr = fetch_pc_q;
  assign o_pc      = pc_q;
  assign o_inst    = inst_q;
  assign o_valid   = valid_q;
`ifdef IF_ADEL_EN
  assign o_adel    = adel_q;
`else
  assign o_adel    = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: cycle table for the basic flow and stall/HOLD, bus-model sequences for redirects and reset.
module tb_if_stage;

  localparam logic [31:0] A0  = 32'hBFC00000;
  localparam logic [31:0] A4  = 32'hBFC00004;
  localparam logic [31:0] A8  = 32'hBFC00008;
  localparam logic [31:0] AC  = 32'hBFC0000C;
  localparam logic [31:0] A10 = 32'hBFC00010;
  localparam logic [31:0] NOBR = 32'hFFFF_FFF1;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jrpc, jpc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] o_pc, o_inst;
  logic        o_valid, o_adel;

  if_stage #(.RESET_PC(A0)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pcsource     (pcsource),
    .bpc          (bpc),
    .jrpc         (jrpc),
    .jpc          (jpc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .o_pc         (o_pc),
    .o_inst       (o_inst),
    .o_valid      (o_valid),
    .o_adel       (o_adel)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic        stall, aok, dok;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t tbl [14];

  // Bus model state
  logic        data_pending;
  logic [31:0] pend_addr;
  int unsigned addr_hold;
  logic        first_seen;
  logic [31:0] first_addr;

  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] br_pc  [2];
  logic [1:0]  br_sel [2];
  logic [31:0] br_tgt [2];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic vec_t mk(input logic s, input logic a, input logic d, input logic [31:0] rd,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.stall = s; v.aok = a; v.dok = d; v.rdata = rd;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_inst = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check);
    reset = 1'b1;
    stall = 1'b0; pcsource = 2'b00; bpc = '0; jrpc = '0; jpc = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    data_pending = 1'b0; addr_hold = 0; first_seen = 1'b0; first_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    if (check) begin
      chk("rst_req",   {31'b0, inst_req}, 32'd0);
      chk("rst_addr",  inst_addr, A0);
      chk("rst_valid", {31'b0, o_valid}, 32'd0);
      chk("rst_pc",    o_pc, 32'd0);
      chk("rst_inst",  o_inst, 32'd0);
      chk("rst_adel",  {31'b0, o_adel}, 32'd0);
    end
    reset = 1'b0;
  endtask

  // Zero-wait responder: addr_ok in the request cycle (after addr_hold cycles), data_ok the cycle after.
  task automatic bus_step();
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    if (data_pending) begin
      inst_data_ok = 1'b1;
      inst_rdata   = mem_word(pend_addr);
      data_pending = 1'b0;
    end else if (inst_req) begin
      if (addr_hold > 0) begin
        addr_hold--;
      end else begin
        inst_addr_ok = 1'b1;
        pend_addr    = inst_addr;
        data_pending = 1'b1;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_addr = inst_addr;
        end
      end
    end
  endtask

  // Runs the bus model until exp_q.size() instructions are accepted, then compares the accepted PCs.
  task automatic run_seq(input string tag, input int unsigned hold, input logic [31:0] forbid);
    int unsigned cyc = 0;
    int unsigned hits = 0;
    got_q.delete();
    while ((got_q.size() < exp_q.size()) && (cyc < 300)) begin
      pcsource = 2'b00;
      bpc = 32'h1111_1110; jrpc = 32'h2222_2220; jpc = 32'h3333_3330;
      if (o_valid && !stall) begin
        got_q.push_back(o_pc);
        if (o_pc[1:0] != 2'b00) begin
          chk($sformatf("%s_adel_flag", tag), {31'b0, o_adel}, 32'd1);
          chk($sformatf("%s_adel_inst", tag), o_inst, 32'd0);
          chk($sformatf("%s_adel_noreq", tag), {31'b0, inst_req}, 32'd0);
        end else begin
          chk($sformatf("%s_adel0", tag), {31'b0, o_adel}, 32'd0);
          chk($sformatf("%s_inst_%h", tag, o_pc), o_inst, mem_word(o_pc));
        end
        for (int i = 0; i < 2; i++) begin
          if (o_pc == br_pc[i]) begin
            pcsource = br_sel[i];
            case (br_sel[i])
              2'b01:   bpc  = br_tgt[i];
              2'b10:   jrpc = br_tgt[i];
              default: jpc  = br_tgt[i];
            endcase
            addr_hold = hold;
          end
        end
      end
      bus_step();
      tick();
      cyc++;
    end
    if (got_q.size() < exp_q.size()) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d accepted, required %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [31:0] g;
      g = (i < got_q.size()) ? got_q[i] : 'x;
      chk($sformatf("%s_pc[%0d]", tag, i), g, exp_q[i]);
    end
    foreach (got_q[k]) if (got_q[k] == forbid) hits++;
    chk($sformatf("%s_no_squashed", tag), hits, 32'd0);
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; pcsource = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, '0,               1'b0, '0,  1'b0, '0,  '0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, '0,               1'b1, A0,  1'b0, '0,  '0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, mem_word(A0),     1'b0, '0,  1'b0, '0,  '0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, '0,               1'b1, A4,  1'b1, A0,  mem_word(A0));
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, mem_word(A4),     1'b0, '0,  1'b0, '0,  '0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, '0,               1'b1, A8,  1'b1, A4,  mem_word(A4));
    tbl[6]  = mk(1'b1, 1'b0, 1'b1, mem_word(A8),     1'b0, '0,  1'b1, A4,  mem_word(A4));
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, '0,               1'b0, '0,  1'b1, A4,  mem_word(A4));
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, '0,               1'b0, '0,  1'b1, A4,  mem_word(A4));
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, '0,               1'b1, AC,  1'b1, A8,  mem_word(A8));
    tbl[10] = mk(1'b0, 1'b0, 1'b1, mem_word(AC),     1'b0, '0,  1'b0, '0,  '0);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, '0,               1'b1, A10, 1'b1, AC,  mem_word(AC));
    tbl[12] = mk(1'b0, 1'b0, 1'b0, '0,               1'b1, A10, 1'b1, AC,  mem_word(AC));
    tbl[13] = mk(1'b0, 1'b0, 1'b0, '0,               1'b1, A10, 1'b0, '0,  '0);

    reset = 1'b0;
    #1;
    do_reset(1'b1);

    for (int i = 0; i < 14; i++) begin
      chk($sformatf("t%0d_req", i), {31'b0, inst_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), inst_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_valid", i), {31'b0, o_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        chk($sformatf("t%0d_pc", i), o_pc, tbl[i].e_pc);
        chk($sformatf("t%0d_inst", i), o_inst, tbl[i].e_inst);
      end
      chk($sformatf("t%0d_adel", i), {31'b0, o_adel}, 32'd0);
      stall        = tbl[i].stall;
      inst_addr_ok = tbl[i].aok;
      inst_data_ok = tbl[i].dok;
      inst_rdata   = tbl[i].rdata;
      tick();
    end

    // Branch with delay slot, zero-wait bus
    do_reset(1'b0);
    br_pc[0] = A10; br_sel[0] = 2'b01; br_tgt[0] = 32'hBFC00100;
    br_pc[1] = NOBR; br_sel[1] = 2'b01; br_tgt[1] = '0;
    exp_q = '{A0, A4, A8, AC, A10, 32'hBFC00014, 32'hBFC00100, 32'hBFC00104};
    run_seq("br", 0, 32'hBFC00018);

    // Same branch, delay-slot request held off by addr_ok for 4 cycles
    do_reset(1'b0);
    run_seq("br_hold", 4, 32'hBFC00018);

    // Jump via jpc
    do_reset(1'b0);
    br_pc[0] = A4; br_sel[0] = 2'b11; br_tgt[0] = 32'hBFC00200;
    exp_q = '{A0, A4, A8, 32'hBFC00200, 32'hBFC00204};
    run_seq("jmp", 0, AC);

    // Jump-register to the top of the address space: fetch PC wraps to 0
    do_reset(1'b0);
    br_pc[0] = A0; br_sel[0] = 2'b10; br_tgt[0] = 32'hFFFF_FFF8;
    exp_q = '{A0, A4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    run_seq("wrap", 0, A8);

    // Reset asserted while a fetch is outstanding; data_ok arrives during and just after reset
    do_reset(1'b0);
    bus_step(); tick();
    bus_step(); tick();
    chk("mid_wait_req", {31'b0, inst_req}, 32'd0);
    reset = 1'b1;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    data_pending = 1'b0; first_seen = 1'b0;
    #1;
    chk("mid_rst_req",   {31'b0, inst_req}, 32'd0);
    chk("mid_rst_addr",  inst_addr, A0);
    chk("mid_rst_valid", {31'b0, o_valid}, 32'd0);
    chk("mid_rst_pc",    o_pc, 32'd0);
    tick();
    chk("mid_rst_valid2", {31'b0, o_valid}, 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_post_valid", {31'b0, o_valid}, 32'd0);
    chk("mid_post_req",   {31'b0, inst_req}, 32'd1);
    chk("mid_post_addr",  inst_addr, A0);
    inst_data_ok = 1'b0;
    br_pc[0] = NOBR;
    exp_q = '{A0, A4};
    run_seq("mid", 0, 32'hDEAD_BEEF);
    chk("mid_first_req", first_addr, A0);

`ifdef IF_ADEL_EN
    // Misaligned jr target: address-error entry, fetch stops until the next redirect
    do_reset(1'b0);
    br_pc[0] = A0;           br_sel[0] = 2'b10; br_tgt[0] = 32'h0040_0002;
    br_pc[1] = 32'h0040_0002; br_sel[1] = 2'b01; br_tgt[1] = 32'hBFC00300;
    exp_q = '{A0, A4, 32'h0040_0002, 32'hBFC00300, 32'hBFC00304};
    run_seq("adel", 0, A8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
